// File: rtl/kgprisc_run_monitor.sv
// kgprisc_run_monitor: run controller and result monitor for the KGPRISC core.
// Holds the core in reset for RESET_HOLD cycles after start, then counts RUN
// cycles until halt (DONE) or until the MAX_CYCLES budget is used up (TIMEOUT).
// NUM_CH result channels are latched when the run ends.
// Optional feature macro: RUN_MON_CHECK_EN adds the expected input and the
// pass/fail outputs, which compare the latched result against expected.
module kgprisc_run_monitor #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 1,
    parameter int CYCLE_W    = 16,
    parameter int MAX_CYCLES = 150,
    parameter int RESET_HOLD = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     halt,
    input  logic [NUM_CH*DATA_W-1:0] result_in,
`ifdef RUN_MON_CHECK_EN
    input  logic [NUM_CH*DATA_W-1:0] expected,
    output logic                     pass,
    output logic                     fail,
`endif
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [NUM_CH*DATA_W-1:0] result_out,
    output logic [CYCLE_W-1:0]       cycles
);

    localparam int RES_W  = NUM_CH * DATA_W;
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    // Last HOLD count before entering RUN, and last RUN count before timeout.
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [CYCLE_W-1:0] RUN_LAST  = CYCLE_W'(MAX_CYCLES - 1);

    // Reject parameter sets that cannot work before anything is built.
    generate
        if (NUM_CH < 1) begin : g_bad_num_ch
            $error("kgprisc_run_monitor: NUM_CH must be >= 1");
        end
        if (RESET_HOLD < 1) begin : g_bad_hold
            $error("kgprisc_run_monitor: RESET_HOLD must be >= 1");
        end
        if (MAX_CYCLES < 1 || (MAX_CYCLES >> CYCLE_W) != 0) begin : g_bad_max
            $error("kgprisc_run_monitor: MAX_CYCLES must be in 1 .. 2^CYCLE_W-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               latch_en;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               match;

`ifdef RUN_MON_CHECK_EN
    assign match = (result_in == expected);
`else
    assign match = 1'b0;
`endif

    // Next-state logic: sequencing of hold, run, end-of-run flags and checks.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cycles_d   = cycles_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        latch_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    cycles_d   = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Every RUN edge counts, including the one that ends the run.
                cycles_d = cycles_q + CYCLE_W'(1);
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (halt) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    latch_en = 1'b1;
                    pass_d   = match;
                    fail_d   = !match;
                end else if (cycles_q == RUN_LAST) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    latch_en  = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-channel result capture, loaded only on the run-ending edge.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign result_d[gi*DATA_W +: DATA_W] = latch_en ? result_in[gi*DATA_W +: DATA_W]
                                                            : result_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            cycles_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            result_q   <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cycles_q   <= cycles_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            result_q   <= result_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign cpu_reset  = (state_q != ST_RUN);
    assign busy       = (state_q == ST_HOLD) || (state_q == ST_RUN);
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign result_out = result_q;
    assign cycles     = cycles_q;
`ifdef RUN_MON_CHECK_EN
    assign pass = pass_q;
    assign fail = fail_q;
`endif

endmodule

// File: tb/tb_kgprisc_run_monitor.sv
// Scoreboard bench for kgprisc_run_monitor (two 32-bit channels, default budget).
module tb_kgprisc_run_monitor;

    localparam int DATA_W     = 32;
    localparam int NUM_CH     = 2;
    localparam int CYCLE_W    = 16;
    localparam int MAX_CYCLES = 150;
    localparam int RESET_HOLD = 10;
    localparam int W          = NUM_CH * DATA_W;

    typedef struct {
        logic         done;
        logic         timeout;
        int           cycles;
        logic [W-1:0] res;
        int           hold;   // -1: not checked
        int           low;    // -1: not checked
        logic         pass;
        logic         fail;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               halt = 1'b0;
    logic [W-1:0]       result_in = '0;
    logic [W-1:0]       expected = '0;
    logic               pass, fail;
    logic               cpu_reset, busy, done, timeout;
    logic [W-1:0]       result_out;
    logic [CYCLE_W-1:0] cycles;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    kgprisc_run_monitor #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CYCLE_W(CYCLE_W),
        .MAX_CYCLES(MAX_CYCLES), .RESET_HOLD(RESET_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .halt(halt),
        .result_in(result_in),
`ifdef RUN_MON_CHECK_EN
        .expected(expected), .pass(pass), .fail(fail),
`endif
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .timeout(timeout),
        .result_out(result_out), .cycles(cycles)
    );

`ifndef RUN_MON_CHECK_EN
    assign pass = 1'b0;
    assign fail = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic d, input logic t, input int c, input logic [W-1:0] r,
                                input int h, input int l, input logic p, input logic f);
        exp_t e;
        e.done = d; e.timeout = t; e.cycles = c; e.res = r;
        e.hold = h; e.low = l; e.pass = p; e.fail = f;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts HOLD/RUN cycles and checks each run end against the scoreboard.
    initial begin : monitor
        logic prev_busy;
        int   hold_seen;
        int   low_seen;
        exp_t e;
        prev_busy = 1'b0;
        hold_seen = 0;
        low_seen  = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (cpu_reset === 1'b1) hold_seen++;
                else low_seen++;
            end else if (prev_busy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL run_end_unexpected: got a run end, expected none");
                end else begin
                    e = sb_q.pop_front();
                    $display("run end: done=%0b timeout=%0b cycles=%0d result=%0h hold=%0d low=%0d",
                             done, timeout, cycles, result_out, hold_seen, low_seen);
                    chk("end_done", 64'(done), 64'(e.done));
                    chk("end_timeout", 64'(timeout), 64'(e.timeout));
                    chk("end_cycles", 64'(cycles), 64'(e.cycles));
                    chk("end_result", 64'(result_out), 64'(e.res));
                    chk("end_cpu_reset", 64'(cpu_reset), 64'd1);
                    if (e.hold >= 0) chk("hold_cycles", 64'(hold_seen), 64'(e.hold));
                    if (e.low >= 0) chk("cpu_reset_low_cycles", 64'(low_seen), 64'(e.low));
`ifdef RUN_MON_CHECK_EN
                    chk("end_pass", 64'(pass), 64'(e.pass));
                    chk("end_fail", 64'(fail), 64'(e.fail));
`endif
                end
                hold_seen = 0;
                low_seen  = 0;
            end
            prev_busy = busy;
        end
    end

    // Start a run; result channel 0 is base+k during RUN cycle k, channel 1 is 1.
    task automatic do_run(input logic [31:0] base, input int halt_at, input int abort_at,
                          input int start_at, input logic [W-1:0] expv, input exp_t e);
        int n;
        sb_q.push_back(e);
        expected = expv;
        halt  = 1'b1;          // halt outside RUN must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        halt  = 1'b0;
        n = 0;
        while (cpu_reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (cpu_reset !== 1'b0) begin
            $display("FAIL run_entry: cpu_reset=%b, expected 0 within 40 cycles", cpu_reset);
            $fatal(1, "core never released");
        end
        for (int k = 1; k <= MAX_CYCLES; k++) begin
            result_in = {32'h1, base + 32'(k)};
            halt  = (k == halt_at);
            abort = (k == abort_at);
            start = (k == start_at);
            tick();
            halt  = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            if (k == halt_at || k == abort_at) break;
        end
        repeat (3) tick();
        chk("sticky_done", 64'(done), 64'(e.done));
        chk("sticky_timeout", 64'(timeout), 64'(e.timeout));
        chk("sticky_cycles", 64'(cycles), 64'(e.cycles));
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    // Directed stimulus.
    initial begin : stim
        int n;
        #1 reset = 1'b1;
        tick();
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_result", 64'(result_out), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        reset = 1'b0;
        tick();

        // Halt on RUN cycle 20, result 0x37, expected matches.
        do_run(32'h23, 20, 0, 0, 64'h1_00000037,
               mk(1'b1, 1'b0, 20, 64'h1_00000037, 10, 20, 1'b1, 1'b0));
        // No halt: budget timeout on RUN cycle 150, result 0x100+150.
        do_run(32'h100, 0, 0, 0, 64'h0,
               mk(1'b0, 1'b1, 150, 64'h1_00000196, 10, 150, 1'b0, 1'b1));
        // Halt on the last budget cycle: halt wins.
        do_run(32'h0, 150, 0, 0, 64'h1_00000096,
               mk(1'b1, 1'b0, 150, 64'h1_00000096, 10, 150, 1'b1, 1'b0));
        // start ignored at RUN cycle 3, abort at RUN cycle 5: result retained.
        do_run(32'h500, 0, 5, 3, 64'h0,
               mk(1'b0, 1'b0, 5, 64'h1_00000096, 10, 5, 1'b0, 1'b0));
        // halt while IDLE does nothing.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("idle_halt_done", 64'(done), 64'd0);
        chk("idle_halt_busy", 64'(busy), 64'd0);
        // Halt on RUN cycle 20 with mismatching expected value.
        do_run(32'h23, 20, 0, 0, 64'h1_00000038,
               mk(1'b1, 1'b0, 20, 64'h1_00000037, 10, 20, 1'b0, 1'b1));

        // Asynchronous reset between edges during RUN cycle 7.
        sb_q.push_back(mk(1'b0, 1'b0, 0, 64'h0, -1, -1, 1'b0, 1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cpu_reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        repeat (6) tick();
        chk("pre_rst_cycles", 64'(cycles), 64'd6);
        #1 reset = 1'b1;
        #1;
        chk("async_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_cycles", 64'(cycles), 64'd0);
        chk("async_result", 64'(result_out), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d runs left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
